// File: rtl/lab3_g29_p3_mux_scanner_pkg.sv
// Shared types and constants for the 16-channel mux scanner.
package lab3_g29_p3_pkg;

    localparam int N_CH    = 16;
    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;

    typedef logic [SEL_W-1:0] ch_idx_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DWELL = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/lab3_g29_p3_mux_scanner_if.sv
// Scanner control/data bundle: sweep handshake, mux select and captured sample.
// The abort input exists only when LAB3_G29_SCAN_ABORT_EN is defined.
interface lab3_g29_p3_mux_scanner_if #(
    parameter int DATA_W = 4
);
    import lab3_g29_p3_pkg::*;

    logic              start;
    logic              continuous;
    logic [N_CH-1:0]   ch_mask;
    logic [DATA_W-1:0] y_in;
`ifdef LAB3_G29_SCAN_ABORT_EN
    logic              abort;
`endif
    ch_idx_t           sel;
    logic              sel_valid;
    logic [DATA_W-1:0] sample;
    ch_idx_t           sample_ch;
    logic              sample_valid;
    logic              busy;
    logic              done;

`ifdef LAB3_G29_SCAN_ABORT_EN
    modport master (
        output start, continuous, ch_mask, y_in, abort,
        input  sel, sel_valid, sample, sample_ch, sample_valid, busy, done
    );
    modport slave (
        input  start, continuous, ch_mask, y_in, abort,
        output sel, sel_valid, sample, sample_ch, sample_valid, busy, done
    );
`else
    modport master (
        output start, continuous, ch_mask, y_in,
        input  sel, sel_valid, sample, sample_ch, sample_valid, busy, done
    );
    modport slave (
        input  start, continuous, ch_mask, y_in,
        output sel, sel_valid, sample, sample_ch, sample_valid, busy, done
    );
`endif

endinterface

// File: rtl/lab3_g29_p3_mux_scanner_next_ch.sv
// Finds the lowest set mask bit strictly above i_idx, or the lowest set bit
// overall when i_first is high. o_found is low when no such bit exists.
module lab3_g29_p3_next_ch
    import lab3_g29_p3_pkg::*;
(
    input  logic [N_CH-1:0] i_mask,
    input  ch_idx_t         i_idx,
    input  logic            i_first,
    output ch_idx_t         o_idx,
    output logic            o_found
);

    // Scan from the top down so the lowest qualifying bit is the last one written.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (i_mask[k] && (i_first || (k > int'(i_idx)))) begin
                o_idx   = ch_idx_t'(k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lab3_g29_p3_mux_scanner.sv
// Mux scanner: steps the 16:1 mux select through the enabled channels, holding
// each for DWELL cycles and capturing y_in (tagged with its channel) at the end
// of every dwell. Single-sweep or continuous, with start/busy/done handshake.
// Optional abort input: define LAB3_G29_SCAN_ABORT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; sel and sample hold their last values
//   S_DWELL | sel drives an enabled channel, dwell counter runs down to 0
//   S_DONE  | one-cycle sweep end: done=1 (plus the last sample, if any)
module lab3_g29_p3_mux_scanner
    import lab3_g29_p3_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DWELL  = 4
) (
    input  logic clk,
    input  logic rst_n,
    lab3_g29_p3_mux_scanner_if.slave bus
);

    localparam logic [DWELL_W-1:0] L_DWELL_M1 = DWELL_W'(DWELL - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_CH-1:0]    r_mask;
    logic [N_CH-1:0]    w_mask_nxt;
    ch_idx_t            r_sel;
    ch_idx_t            w_sel_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_capture;
    logic [DATA_W-1:0]  r_sample;
    ch_idx_t            r_sample_ch;
    logic               r_sample_valid;

    logic [N_CH-1:0]    w_first_mask;
    ch_idx_t            w_first_idx;
    logic               w_first_found;
    ch_idx_t            w_above_idx;
    logic               w_above_found;
    logic               w_abort;

`ifdef LAB3_G29_SCAN_ABORT_EN
    assign w_abort = bus.abort;
`else
    assign w_abort = 1'b0;
`endif

    // In IDLE the lowest channel comes from the live mask (it is being
    // snapshotted this cycle); once running, wraps use the snapshot.
    assign w_first_mask = (r_state == S_IDLE) ? bus.ch_mask : r_mask;

    lab3_g29_p3_next_ch u_first (
        .i_mask  (w_first_mask),
        .i_idx   ('0),
        .i_first (1'b1),
        .o_idx   (w_first_idx),
        .o_found (w_first_found)
    );

    lab3_g29_p3_next_ch u_above (
        .i_mask  (r_mask),
        .i_idx   (r_sel),
        .i_first (1'b0),
        .o_idx   (w_above_idx),
        .o_found (w_above_found)
    );

    // Next-state, next-channel and dwell-counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_first_found) begin
                        w_mask_nxt  = bus.ch_mask;
                        w_sel_nxt   = w_first_idx;
                        w_cnt_nxt   = L_DWELL_M1;
                        w_state_nxt = S_DWELL;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DWELL: begin
                if (w_abort) begin
                    // Interrupted channel is dropped: no capture.
                    w_state_nxt = S_DONE;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else begin
                    // Capture and channel advance share one edge, so there
                    // is no gap cycle between channels.
                    w_capture = 1'b1;
                    w_cnt_nxt = L_DWELL_M1;
                    if (w_above_found) begin
                        w_sel_nxt = w_above_idx;
                    end else if (bus.continuous) begin
                        w_sel_nxt = w_first_idx;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mask snapshot, select, dwell counter and captured sample registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask         <= '0;
            r_sel          <= '0;
            r_cnt          <= '0;
            r_sample       <= '0;
            r_sample_ch    <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_mask         <= w_mask_nxt;
            r_sel          <= w_sel_nxt;
            r_cnt          <= w_cnt_nxt;
            r_sample_valid <= w_capture;
            if (w_capture) begin
                r_sample    <= bus.y_in;
                r_sample_ch <= r_sel;
            end
        end
    end

    assign bus.sel          = r_sel;
    assign bus.sel_valid    = (r_state == S_DWELL);
    assign bus.busy         = (r_state == S_DWELL);
    assign bus.done         = (r_state == S_DONE);
    assign bus.sample       = r_sample;
    assign bus.sample_ch    = r_sample_ch;
    assign bus.sample_valid = r_sample_valid;

endmodule

// File: tb/tb_lab3_g29_p3_mux_scanner.sv
// Directed bench for the mux scanner with a sample scoreboard. The mux is
// modelled as a 16-entry table indexed by sel.
module tb_lab3_g29_p3_mux_scanner;
    import lab3_g29_p3_pkg::*;

    localparam int DW    = 4;
    localparam int DWELL = 4;

    typedef struct packed {
        logic [3:0]    ch;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] mux_in [16];
    exp_t          sb [$];
    int            n_cmp = 0;
    int            n_fail = 0;

    lab3_g29_p3_mux_scanner_if #(.DATA_W(DW)) bus ();

    assign bus.y_in = mux_in[bus.sel];

    lab3_g29_p3_mux_scanner #(.DATA_W(DW), .DWELL(DWELL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch);
        exp_t e;
        e.ch   = 4'(ch);
        e.data = mux_in[ch];
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and score any sample strobe seen there.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (bus.sample_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed sample_ch %0d, expected no sample", bus.sample_ch);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_ch", 32'(bus.sample_ch), 32'(e.ch));
                chk("sb_data", 32'(bus.sample), 32'(e.data));
            end
        end
    endtask

    task automatic chk_ctl(input string tag, input int e_sel, input logic e_busy,
                           input logic e_sv, input logic e_done);
        chk({tag, "_sel"}, 32'(bus.sel), 32'(e_sel));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(e_busy));
        chk({tag, "_selv"}, 32'(bus.sel_valid), 32'(e_busy));
        chk({tag, "_sv"}, 32'(bus.sample_valid), 32'(e_sv));
        chk({tag, "_done"}, 32'(bus.done), 32'(e_done));
    endtask

    task automatic chk_drained(input string tag);
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    // Single sweep over mask; optionally disturb mask/start mid-sweep.
    task automatic run_sweep(input string tag, input logic [15:0] mask, input bit perturb);
        int chs [$];
        int n;
        int last;
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) begin
                chs.push_back(k);
                push(k);
            end
        end
        n    = chs.size();
        last = n * DWELL + 1;
        bus.ch_mask    = mask;
        bus.continuous = 1'b0;
        bus.start      = 1'b1;
        for (int c = 1; c <= last + 1; c++) begin
            tick();
            if (c < last) begin
                chk_ctl(tag, chs[(c - 1) / DWELL], 1'b1, (c > 1) && ((c - 1) % DWELL == 0), 1'b0);
            end else begin
                chk_ctl(tag, chs[n - 1], 1'b0, (c == last), (c == last));
            end
            bus.start   = 1'b0;
            bus.ch_mask = mask;
            if (perturb && (c == 3 || c == DWELL + 2)) begin
                bus.ch_mask = 16'hFFFF;
                bus.start   = 1'b1;
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        end
        chk_drained({tag, "_drain"});
    endtask

    // Continuous scan; continuous drops during the 4th dwell, giving 4 samples.
    task automatic run_cont(input string tag, input logic [15:0] mask);
        int chs [$];
        int n;
        for (int k = 0; k < 16; k++) begin
            if (mask[k]) chs.push_back(k);
        end
        n = chs.size();
        for (int i = 0; i < 4; i++) push(chs[i % n]);
        bus.ch_mask    = mask;
        bus.continuous = 1'b1;
        bus.start      = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            bus.start = 1'b0;
            if (c <= 16) begin
                chk_ctl(tag, chs[((c - 1) / DWELL) % n], 1'b1,
                        (c > 1) && ((c - 1) % DWELL == 0), 1'b0);
            end else begin
                chk_ctl(tag, chs[(4 - 1) % n], 1'b0, (c == 17), (c == 17));
            end
            if (c == 14) bus.continuous = 1'b0;
        end
        chk_drained({tag, "_drain"});
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mux_in[k] = 4'(k);
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_mask    = '0;
`ifdef LAB3_G29_SCAN_ABORT_EN
        bus.abort      = 1'b0;
`endif
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_ctl("reset", 0, 1'b0, 1'b0, 1'b0);
        chk("reset_sample", 32'(bus.sample), 32'd0);
        chk("reset_sample_ch", 32'(bus.sample_ch), 32'd0);
        rst_n = 1'b1;
        tick();

        run_sweep("sweep05", 16'h0005, 1'b0);
        run_sweep("midsweep", 16'h0005, 1'b1);

        // Empty mask: done next cycle, never busy, no sample.
        bus.ch_mask = '0;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd0);
        chk("zero_sv", 32'(bus.sample_valid), 32'd0);
        tick();
        chk("zero_done_off", 32'(bus.done), 32'd0);
        chk("zero_busy_off", 32'(bus.busy), 32'd0);
        tick();

        run_cont("cont8001", 16'h8001);
        tick();
        run_cont("cont0010", 16'h0010);
        tick();

`ifdef LAB3_G29_SCAN_ABORT_EN
        // Abort during the ch2 dwell: only the ch0 sample is produced.
        push(0);
        bus.ch_mask = 16'h0005;
        bus.start   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            if (c <= 6) chk_ctl("abort", (c <= 4) ? 0 : 2, 1'b1, (c == 5), 1'b0);
            else        chk_ctl("abort", 2, 1'b0, 1'b0, (c == 7));
            if (c == 6) bus.abort = 1'b1;
        end
        chk("abort_sample", 32'(bus.sample), 32'(mux_in[0]));
        chk_drained("abort_drain");
`endif

        // Distinct mux data so sample and sample_ch are independently checked.
        for (int k = 0; k < 16; k++) mux_in[k] = ~4'(k);
        run_sweep("inv0421", 16'h0421, 1'b0);
        run_sweep("top8000", 16'h8000, 1'b0);

        // Asynchronous reset mid-sweep, checked between clock edges.
        bus.ch_mask = 16'h0004;
        bus.start   = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("rst_pre_sel", 32'(bus.sel), 32'd2);
        chk("rst_pre_busy", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_ctl("async_rst", 0, 1'b0, 1'b0, 1'b0);
        chk("async_rst_sample", 32'(bus.sample), 32'd0);
        chk("async_rst_sample_ch", 32'(bus.sample_ch), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lab3_g29_p3_mux_scanner.md
Name: lab3_g29_p3_mux_scanner

Overview:
Sequencer directly upstream/around the 16x1, 4-bit mux stage. Drives the mux select through the channels enabled in a 16-bit mask and holds each channel for DWELL cycles. At the end of each dwell it captures the mux output (y) and tags it with the channel number. Supports single-sweep and continuous scanning with a start/busy/done handshake.

Parameters:
N_CH, 16, number of mux channels (fixed at 16 for this lab; sets the mask width).
SEL_W, 4, select/channel-tag width (log2 N_CH).
DATA_W, 4, mux data width.
DWELL, 4, cycles each channel is held before capture; legal range 1..255.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
continuous  in  1  1 = wrap to the lowest enabled channel after the highest; sampled at each wrap point.
ch_mask  in  16  channel enable mask; bit k enables channel k; snapshotted on an accepted start.
y_in  in  DATA_W  mux output (dut y).
sel  out  SEL_W  mux select.
sel_valid  out  1  1 while sel addresses an enabled channel under dwell.
sample  out  DATA_W  captured y_in.
sample_ch  out  SEL_W  channel of the captured sample.
sample_valid  out  1  one-cycle strobe for a new sample/sample_ch pair.
busy  out  1  sweep in progress.
done  out  1  one-cycle strobe at sweep end.

Behaviour:
- Reset (asynchronous, any state): state=IDLE and all outputs 0 (sel=0, sample=0, sample_ch=0). Mask snapshot, dwell counter and continuous latch are cleared.
- FSM states: IDLE, DWELL, DONE.
- IDLE with start=1 and ch_mask!=0: snapshot the mask. Next cycle: state=DWELL, sel=lowest set bit, busy=1, sel_valid=1, dwell counter=DWELL-1.
- IDLE with start=1 and ch_mask==0: go to DONE. done=1 for one cycle; no sample_valid; busy stays 0.
- DWELL: sel is held stable and the counter decrements. On the cycle where counter==0:
  - y_in is registered into sample and sel into sample_ch.
  - sample_valid=1 in the following cycle.
  - The FSM moves to the next set bit strictly above sel in the snapshot. sel updates in the same cycle that sample_valid is high.
- No higher set bit and continuous=1: wrap to the lowest set bit and stay in DWELL.
- No higher set bit and continuous=0: go to DONE. In the DONE cycle, sample_valid=1 (last sample), done=1, busy=0, sel_valid=0, sel holds its last value. DONE then returns to IDLE.
- Per-channel period is exactly DWELL cycles. There are no gap cycles between channels.
- Start accepted at cycle t: first sample_valid at t+DWELL+1.
- A single-bit mask with continuous=1 re-dwells the same channel indefinitely, producing a sample every DWELL cycles.
- ch_mask changes while busy are ignored (snapshot in use).
- start while busy is ignored and not queued.
- Deasserting continuous mid-pass lets the current pass finish, then the FSM goes to DONE.
- sample/sample_ch hold their value between strobes.

Optional Feature:
LAB3_G29_SCAN_ABORT_EN
- Defined: adds input abort (1 bit). abort=1 while busy forces DONE on the next cycle: done=1, no sample_valid for the interrupted channel, sample keeps its previous value. abort in IDLE has no effect.
- Undefined: the port and its logic are absent; sweeps can only end naturally or by reset.

Decomposition:
- Package lab3_g29_p3_pkg holds:
  - the state enum type (IDLE, DWELL, DONE);
  - localparams N_CH=16 and SEL_W=4;
  - the typedef for the channel index.
- One combinational sub-module, lab3_g29_p3_next_ch, takes (mask, current index) and returns (next set index strictly above, found flag). The same sub-module with index -1 semantics (a "first" input) yields the lowest set bit.

Test Plan:
(Tie mux in_k=k so y equals the channel number; DWELL=4.)
1. Reset: rst_n=0 mid-sweep -> sel=0, busy=0, sel_valid=0, sample_valid=0, done=0 immediately, without waiting for a clock edge.
2. ch_mask=16'h0005, continuous=0, start pulse at t:
   - sel=0 for t+1..t+4; sample_valid at t+5 with sample=0, sample_ch=0.
   - sel=2 for t+5..t+8; at t+9 sample=2, sample_ch=2, sample_valid=1 and done=1.
   - busy=0 from t+9.
3. ch_mask=0, start -> done=1 at next cycle; busy never 1; no sample_valid.
4. ch_mask=16'h8001, continuous=1 -> samples ch0, 15, 0, 15 every 4 cycles. Drop continuous during the second ch15 dwell -> done coincides with that ch15 sample.
5. Mid-sweep: change ch_mask to 16'hFFFF and pulse start -> sequence unchanged (still ch0, ch2 only); no second sweep.
6. With LAB3_G29_SCAN_ABORT_EN: abort during ch2 dwell -> done next cycle, sample stays 0, no ch2 sample. Without the macro: build has no abort port.
